// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Register-file issue/writeback controller around an 8-bit logic ALU;
//            one instruction per three cycles with a one-cycle done strobe.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [1:0]       instr_rd,
    input  logic [1:0]       instr_rs1,
    input  logic [1:0]       instr_rs2,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    output logic [1:0]       done_rd,
    output logic [WIDTH-1:0] done_data,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_rd_q;
    logic [WIDTH-1:0] r_regs [NREG];
    logic             w_accept;

    assign instr_ready = (r_state == ST_IDLE);
    assign w_accept    = instr_valid && instr_ready;
    assign dbg_data    = r_regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = ST_WB;
            ST_WB:   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Writeback is assigned after the direct load so it wins on an address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                r_regs[ld_addr] <= ld_data;
            end
            if (r_state == ST_EXEC) begin
                r_regs[r_rd_q] <= alu_result;
            end
        end
    end

    // Operands are sampled from the pre-edge register contents, so a same-edge
    // load to a source register is not seen by the accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 2'b00;
            r_rd_q     <= 2'b00;
        end else if (w_accept) begin
            alu_a      <= r_regs[instr_rs1];
            alu_b      <= r_regs[instr_rs2];
            alu_opcode <= instr_op;
            r_rd_q     <= instr_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            done_rd   <= 2'b00;
            done_data <= '0;
        end else begin
            done <= (r_state == ST_EXEC);
            if (r_state == ST_EXEC) begin
                done_rd   <= r_rd_q;
                done_data <= alu_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Directed self-checking bench for alu_issue_ctrl with a logic-ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_opcode;
    logic [7:0] alu_result;
    logic       done;
    logic [1:0] done_rd;
    logic [7:0] done_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .done(done), .done_rd(done_rd), .done_data(done_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Combinational logic ALU
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = ~(alu_a & alu_b);
            default: alu_result = ~(alu_a | alu_b);
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, rd, rs1, rs2,
                         input logic [7:0] ea, eb, er, input string name);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL %s exec_ready: got %b required 0", name, instr_ready); end
        checks++; if (alu_a !== ea) begin errors++; $display("FAIL %s alu_a: got %h required %h", name, alu_a, ea); end
        checks++; if (alu_b !== eb) begin errors++; $display("FAIL %s alu_b: got %h required %h", name, alu_b, eb); end
        checks++; if (alu_opcode !== op) begin errors++; $display("FAIL %s alu_opcode: got %b required %b", name, alu_opcode, op); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s exec_done: got %b required 0", name, done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s wb_done: got %b required 1", name, done); end
        checks++; if (done_rd !== rd) begin errors++; $display("FAIL %s done_rd: got %0d required %0d", name, done_rd, rd); end
        checks++; if (done_data !== er) begin errors++; $display("FAIL %s done_data: got %h required %h", name, done_data, er); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL %s wb_ready: got %b required 0", name, instr_ready); end
        dbg_addr = rd; #1;
        checks++; if (dbg_data !== er) begin errors++; $display("FAIL %s dbg_rd: got %h required %h", name, dbg_data, er); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s idle_done: got %b required 0", name, done); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready: got %b required 1", name, instr_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", instr_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_opcode !== 2'b00) begin
            errors++; $display("FAIL reset_alu: got a=%h b=%h op=%b required 00 00 00", alu_a, alu_b, alu_opcode);
        end
        checks++; if (done_rd !== 2'd0 || done_data !== 8'h00) begin
            errors++; $display("FAIL reset_done_fields: got rd=%0d data=%h required 0 00", done_rd, done_data);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h required 00", i, dbg_data); end
        end
    endtask

    task automatic test_and();
        load(2'd0, 8'hF0);
        load(2'd1, 8'h3C);
        issue(2'b00, 2'd2, 2'd0, 2'd1, 8'hF0, 8'h3C, 8'h30, "and_r2");
    endtask

    task automatic test_ops();
        issue(2'b01, 2'd3, 2'd0, 2'd1, 8'hF0, 8'h3C, 8'hFC, "or_r3");
        issue(2'b10, 2'd3, 2'd0, 2'd1, 8'hF0, 8'h3C, 8'hCF, "nand_r3");
        issue(2'b11, 2'd3, 2'd0, 2'd1, 8'hF0, 8'h3C, 8'h03, "nor_r3");
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops  [3] = '{2'b01, 2'b00, 2'b11};
        logic [1:0] rds  [3] = '{2'd3, 2'd2, 2'd2};
        logic [1:0] rs1s [3] = '{2'd0, 2'd0, 2'd3};
        logic [1:0] rs2s [3] = '{2'd1, 2'd1, 2'd0};
        logic [7:0] exps [3] = '{8'hFC, 8'h30, 8'h03};
        int idx = 0;
        int dn  = 0;
        for (int k = 0; k < 10; k++) begin
            if (idx < 3) begin
                instr_valid = 1'b1; instr_op = ops[idx]; instr_rd = rds[idx];
                instr_rs1 = rs1s[idx]; instr_rs2 = rs2s[idx];
            end else begin
                instr_valid = 1'b0;
            end
            #1;
            checks++; if (instr_ready !== (k % 3 == 0)) begin errors++; $display("FAIL b2b_ready_c%0d: got %b required %b", k, instr_ready, (k % 3 == 0)); end
            checks++; if (done !== (k % 3 == 2)) begin errors++; $display("FAIL b2b_done_c%0d: got %b required %b", k, done, (k % 3 == 2)); end
            if (k % 3 == 2 && dn < 3) begin
                checks++; if (done_data !== exps[dn] || done_rd !== rds[dn]) begin
                    errors++; $display("FAIL b2b_result%0d: got rd=%0d data=%h required rd=%0d data=%h", dn, done_rd, done_data, rds[dn], exps[dn]);
                end
                dn++;
            end
            if (instr_valid && instr_ready) idx++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_collision();
        // Same-address clash: writeback overrides the direct load
        instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        @(negedge clk);
        instr_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
        @(negedge clk);
        ld_en = 1'b0;
        dbg_addr = 2'd2; #1;
        checks++; if (dbg_data !== 8'h30) begin errors++; $display("FAIL collide_same_r2: got %h required 30", dbg_data); end
        @(negedge clk);
        // Different address: both writes land
        load(2'd2, 8'h55);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'hAA;
        @(negedge clk);
        ld_en = 1'b0;
        dbg_addr = 2'd2; #1;
        checks++; if (dbg_data !== 8'h30) begin errors++; $display("FAIL collide_diff_r2: got %h required 30", dbg_data); end
        dbg_addr = 2'd3; #1;
        checks++; if (dbg_data !== 8'hAA) begin errors++; $display("FAIL collide_diff_r3: got %h required AA", dbg_data); end
        @(negedge clk);
    endtask

    task automatic test_accept_load();
        instr_valid = 1'b1; instr_op = 2'b01; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h00;
        @(negedge clk);
        instr_valid = 1'b0; ld_en = 1'b0;
        checks++; if (alu_a !== 8'hF0) begin errors++; $display("FAIL accept_load_alu_a: got %h required F0", alu_a); end
        @(negedge clk);
        checks++; if (done_data !== 8'hFC) begin errors++; $display("FAIL accept_load_result: got %h required FC", done_data); end
        dbg_addr = 2'd0; #1;
        checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL accept_load_r0: got %h required 00", dbg_data); end
        @(negedge clk);
        issue(2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 8'h3C, 8'h3C, "or_after_load");
    endtask

    task automatic test_reset_mid();
        instr_valid = 1'b1; instr_op = 2'b01; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if (alu_a !== 8'h3C) begin errors++; $display("FAIL mid_pre_alu_a: got %h required 3C", alu_a); end
        #2 rst = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready: got %b required 1", instr_ready); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("FAIL mid_async_alu: got a=%h b=%h required 00 00", alu_a, alu_b); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin
                errors++; $display("FAIL mid_after_c%0d: got done=%b ready=%b required 0 1", k, done, instr_ready);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL mid_reg%0d: got %h required 00", i, dbg_data); end
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = 2'b00; instr_rd = 2'd0;
        instr_rs1 = 2'd0; instr_rs2 = 2'd0; ld_en = 1'b0; ld_addr = 2'd0;
        ld_data = 8'h00; dbg_addr = 2'd0;
        @(negedge clk);
        test_reset();
        test_and();
        test_ops();
        test_back_to_back();
        test_collision();
        test_accept_load();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
